// File: rtl/bwave_instr_fetch.sv
// bwave_instr_fetch: instruction RAM plus fetch pipeline feeding the NPU.
// The host loads the program while load_en is high. The NPU then fetches
// words by address. Fetches at or beyond the program length return an
// END_CHAIN word and raise the sticky prog_done flag.
module bwave_instr_fetch #(
   parameter int INSTR_WIDTH      = 46,
   parameter int INSTR_MEM_AWIDTH = 10,
   parameter int OPCODE_WIDTH     = 4,
   parameter int END_CHAIN_OPCODE = 12
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        load_en,
   input  logic                        load_we,
   input  logic [INSTR_MEM_AWIDTH-1:0] load_addr,
   input  logic [INSTR_WIDTH-1:0]      load_data,
   input  logic [INSTR_MEM_AWIDTH:0]   prog_len,
   input  logic                        get_instr,
   input  logic [INSTR_MEM_AWIDTH-1:0] get_instr_addr,
   output logic [INSTR_WIDTH-1:0]      instruction,
   output logic                        instr_valid,
   output logic                        prog_done,
   output logic [15:0]                 fetch_count,
   output logic                        fetch_err
);

   localparam int DEPTH = 1 << INSTR_MEM_AWIDTH;
   localparam logic [OPCODE_WIDTH-1:0] END_OP = OPCODE_WIDTH'(END_CHAIN_OPCODE);
   localparam logic [INSTR_WIDTH-1:0]  END_WORD =
      {END_OP, {(INSTR_WIDTH-OPCODE_WIDTH){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FETCH} state_t;

   state_t                      state;
   logic [INSTR_WIDTH-1:0]      mem [DEPTH];
   logic [INSTR_MEM_AWIDTH:0]   len_q;

   logic [INSTR_MEM_AWIDTH-1:0] rd_addr_p0;
   logic                        oor_p0;
   logic                        vld_p0;
   logic [INSTR_WIDTH-1:0]      rd_data_p1;
   logic                        oor_p1;
   logic                        vld_p1;

   logic                        accept;
   logic                        out_of_range;

   // A fetch is only taken once the host has released the RAM and the
   // program length has been latched (i.e. not during the LOAD exit cycle).
   assign accept       = get_instr && !load_en && (state != S_LOAD);
   assign out_of_range = {1'b0, get_instr_addr} >= len_q;

   // RAM write port and data pipeline (read-first; no reset on data)
   always_ff @(posedge clk) begin
      if (load_en && load_we)
         mem[load_addr] <= load_data;
      // p0: address and range flag registered
      if (accept) begin
         rd_addr_p0 <= get_instr_addr;
         oor_p0     <= out_of_range;
      end
      // p1: RAM word registered
      rd_data_p1 <= mem[rd_addr_p0];
      oor_p1     <= oor_p0;
   end

   // Control FSM, valid pipeline and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         len_q       <= '0;
         vld_p0      <= 1'b0;
         vld_p1      <= 1'b0;
         instruction <= '0;
         instr_valid <= 1'b0;
         prog_done   <= 1'b0;
         fetch_count <= '0;
         fetch_err   <= 1'b0;
      end else begin
         instr_valid <= 1'b0;
         if (load_en) begin
            // Host owns the RAM: abort anything in flight, flag stray fetches
            state  <= S_LOAD;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            if (get_instr)
               fetch_err <= 1'b1;
         end else if (state == S_LOAD) begin
            state     <= S_IDLE;
            len_q     <= prog_len;
            prog_done <= 1'b0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
         end else begin
            state  <= accept ? S_FETCH : S_IDLE;
            vld_p0 <= accept;
            vld_p1 <= vld_p0;
            // p2: word presented to the NPU
            if (vld_p1) begin
               instr_valid <= 1'b1;
               instruction <= oor_p1 ? END_WORD : rd_data_p1;
               if (oor_p1)
                  prog_done <= 1'b1;
               if (fetch_count != 16'hFFFF)
                  fetch_count <= fetch_count + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_bwave_instr_fetch.sv
// Testbench for bwave_instr_fetch: directed stimulus with a scoreboard queue
// of expected words and fetch counts, drained by an independent monitor.
module tb_bwave_instr_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_en;
   logic        load_we;
   logic [9:0]  load_addr;
   logic [45:0] load_data;
   logic [10:0] prog_len;
   logic        get_instr;
   logic [9:0]  get_instr_addr;
   logic [45:0] instruction;
   logic        instr_valid;
   logic        prog_done;
   logic [15:0] fetch_count;
   logic        fetch_err;

   typedef struct packed {
      logic [45:0] w;
      logic [15:0] c;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] exp_cnt  = 16'd0;

   localparam logic [45:0] END_W = 46'h3000_0000_0000;

   bwave_instr_fetch dut (
      .clk            (clk),
      .rst            (rst),
      .load_en        (load_en),
      .load_we        (load_we),
      .load_addr      (load_addr),
      .load_data      (load_data),
      .prog_len       (prog_len),
      .get_instr      (get_instr),
      .get_instr_addr (get_instr_addr),
      .instruction    (instruction),
      .instr_valid    (instr_valid),
      .prog_done      (prog_done),
      .fetch_count    (fetch_count),
      .fetch_err      (fetch_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", nm, act, req);
      end
   endtask

   // Monitor: every instr_valid pulse must match the oldest expected entry
   always @(negedge clk) begin
      if (rst === 1'b1 && instr_valid === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_valid: actual instruction=%h required no valid", instruction);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("instruction", 64'(instruction), 64'(e.w));
            chk("fetch_count", 64'(fetch_count), 64'(e.c));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic [9:0] a, input logic [45:0] d);
      load_en   = 1'b1;
      load_we   = 1'b1;
      load_addr = a;
      load_data = d;
      tick();
      load_we   = 1'b0;
   endtask

   task automatic end_load(input logic [10:0] len);
      load_en  = 1'b1;
      prog_len = len;
      tick();
      load_en  = 1'b0;
      tick();
   endtask

   // One-cycle fetch request; consecutive calls make back-to-back requests
   task automatic fetch(input logic [9:0] a, input logic [45:0] w);
      exp_t e;
      get_instr      = 1'b1;
      get_instr_addr = a;
      exp_cnt        = exp_cnt + 16'd1;
      e.w = w;
      e.c = exp_cnt;
      sb.push_back(e);
      tick();
      get_instr = 1'b0;
   endtask

   task automatic drain(input string nm);
      int cyc;
      cyc = 0;
      while (sb.size() != 0 && cyc < 20) begin
         tick();
         cyc++;
      end
      tick();
      chk({nm, "_drained"}, 64'(sb.size()), 64'd0);
      sb.delete();
   endtask

   initial begin
      rst = 1'b0; load_en = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
      prog_len = '0; get_instr = 1'b0; get_instr_addr = '0;
      #3;
      chk("rst_instruction", 64'(instruction), 64'd0);
      chk("rst_valid", 64'(instr_valid), 64'd0);
      chk("rst_prog_done", 64'(prog_done), 64'd0);
      chk("rst_count", 64'(fetch_count), 64'd0);
      chk("rst_fetch_err", 64'(fetch_err), 64'd0);
      tick();
      rst = 1'b1;
      tick();

      // Load a four-word program
      for (int i = 0; i < 4; i++)
         load_word(10'(i), 46'h1000_0000_0001 + 46'(i));
      end_load(11'd4);

      // Single fetch, then four back-to-back fetches
      fetch(10'd2, 46'h1000_0000_0003);
      drain("single");
      for (int i = 0; i < 4; i++)
         fetch(10'(i), 46'h1000_0000_0001 + 46'(i));
      drain("burst");

      // Write strobe without load_en must not change the RAM
      load_we = 1'b1; load_addr = 10'd0; load_data = 46'h2AAA_AAAA_AAAA;
      tick();
      load_we = 1'b0;
      fetch(10'd0, 46'h1000_0000_0001);
      drain("we_ignored");

      // Out-of-range fetch returns END_CHAIN and sets sticky prog_done
      chk("prog_done_before_oor", 64'(prog_done), 64'd0);
      fetch(10'd4, END_W);
      drain("oor");
      chk("prog_done_set", 64'(prog_done), 64'd1);
      fetch(10'd0, 46'h1000_0000_0001);
      drain("after_oor");
      chk("prog_done_sticky", 64'(prog_done), 64'd1);

      // Fetch during load is dropped and flagged
      load_en = 1'b1;
      tick();
      get_instr = 1'b1; get_instr_addr = 10'd1;
      tick();
      get_instr = 1'b0;
      tick(); tick(); tick();
      chk("fetch_err_set", 64'(fetch_err), 64'd1);
      load_en = 1'b0;
      tick();
      chk("prog_done_cleared", 64'(prog_done), 64'd0);
      chk("fetch_err_sticky", 64'(fetch_err), 64'd1);

      // Reset in the middle of a fetch
      get_instr = 1'b1; get_instr_addr = 10'd1;
      tick();
      get_instr = 1'b0;
      rst = 1'b0;
      #1;
      sb.delete();
      exp_cnt = 16'd0;
      chk("midrst_instruction", 64'(instruction), 64'd0);
      chk("midrst_valid", 64'(instr_valid), 64'd0);
      chk("midrst_count", 64'(fetch_count), 64'd0);
      chk("midrst_fetch_err", 64'(fetch_err), 64'd0);
      tick(); tick(); tick();
      chk("midrst_no_pulse", 64'(instr_valid), 64'd0);
      rst = 1'b1;
      tick();
      end_load(11'd4);
      fetch(10'd0, 46'h1000_0000_0001);
      drain("ram_kept");

      // Full-depth program: top address is in range
      load_word(10'd1023, 46'h3FFF_FFFF_FFFF);
      end_load(11'd1024);
      fetch(10'd1023, 46'h3FFF_FFFF_FFFF);
      drain("full_depth");
      chk("full_depth_prog_done", 64'(prog_done), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
